// File: rtl/mem_io_bridge_if.sv
// mem_io_bridge_if: bus bundle between the CPU datapath, data memory and NUM_IO peripheral channels.
// Parameters: DW, AW, IO_DW, NUM_IO, IO_OFF_W (must match the bridge instance).
// Modports: master = bridge side (drives cpu_rdata/stall/err, memory port, peripheral requests);
//           slave  = CPU/memory/peripheral side (drives strobes, address, write data, read data, acks).
interface mem_io_bridge_if #(
    parameter int DW       = 32,
    parameter int AW       = 32,
    parameter int IO_DW    = 24,
    parameter int NUM_IO   = 4,
    parameter int IO_OFF_W = 4
);
    logic                    cpu_mread;
    logic                    cpu_mwrite;
    logic                    cpu_ioread;
    logic                    cpu_iowrite;
    logic [AW-1:0]           cpu_addr;
    logic [DW-1:0]           cpu_wdata;
    logic [DW-1:0]           cpu_rdata;
    logic                    cpu_stall;
    logic                    err;
    logic [AW-1:0]           mem_addr;
    logic [DW-1:0]           mem_wdata;
    logic                    mem_we;
    logic [DW-1:0]           mem_rdata;
    logic [NUM_IO-1:0]       io_sel;
    logic [IO_OFF_W-1:0]     io_addr;
    logic [IO_DW-1:0]        io_wdata;
    logic                    io_rd;
    logic                    io_wr;
    logic [NUM_IO*IO_DW-1:0] io_rdata;
    logic [NUM_IO-1:0]       io_ack;

    modport master (
        input  cpu_mread, cpu_mwrite, cpu_ioread, cpu_iowrite, cpu_addr, cpu_wdata,
        input  mem_rdata, io_rdata, io_ack,
        output cpu_rdata, cpu_stall, err, mem_addr, mem_wdata, mem_we,
        output io_sel, io_addr, io_wdata, io_rd, io_wr
    );

    modport slave (
        output cpu_mread, cpu_mwrite, cpu_ioread, cpu_iowrite, cpu_addr, cpu_wdata,
        output mem_rdata, io_rdata, io_ack,
        input  cpu_rdata, cpu_stall, err, mem_addr, mem_wdata, mem_we,
        input  io_sel, io_addr, io_wdata, io_rd, io_wr
    );
endinterface

// File: rtl/mem_io_bridge.sv
// mem_io_bridge: multi-cycle router of CPU load/store strobes to one data-memory port and NUM_IO peripheral channels.
// Ports: clock (rising edge), reset_n (async active-low), b (mem_io_bridge_if.master: CPU strobes/address/data in,
//        cpu_rdata/cpu_stall/err out, memory port, one-hot peripheral select with rd/wr request and per-channel ack).
// Optional: define MEMIO_TIMEOUT_EN to abort IO accesses that see no ack within TIMEOUT cycles.
module mem_io_bridge #(
    parameter int DW       = 32,
    parameter int AW       = 32,
    parameter int IO_DW    = 24,
    parameter int NUM_IO   = 4,
    parameter int IO_OFF_W = 4,
    parameter int MEM_LAT  = 1,
    parameter int TIMEOUT  = 15
) (
    input logic             clock,
    input logic             reset_n,
    mem_io_bridge_if.master b
);
    typedef enum logic [1:0] {IDLE, MEM, IO, DONE} state_t;

    state_t           state;
    logic [2:0]       lat_cnt;
    logic             rd_op;
    logic [3:0]       strb;
    logic             any;
    logic             multi;
    logic             is_mem;
    logic             is_read;
    logic             bad_ch;
    logic [IO_DW-1:0] sel_rdata;
`ifdef MEMIO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;
`endif

    assign strb    = {b.cpu_mread, b.cpu_mwrite, b.cpu_ioread, b.cpu_iowrite};
    assign any     = |strb;
    // more than one bit set <=> clearing the lowest set bit leaves something behind
    assign multi   = |(strb & (strb - 4'd1));
    assign is_mem  = b.cpu_mread | b.cpu_mwrite;
    assign is_read = b.cpu_mread | (!b.cpu_mwrite & b.cpu_ioread);
    assign bad_ch  = {1'b0, b.cpu_addr[IO_OFF_W +: 4]} >= 5'(NUM_IO);
    // stall must rise in the same cycle the CPU raises a strobe, so it is decoded rather than registered
    assign b.cpu_stall = reset_n & ((state == IDLE) ? any : (state != DONE));

    always_comb begin
        sel_rdata = '0;
        for (int k = 0; k < NUM_IO; k++)
            if (b.io_sel[k]) sel_rdata = b.io_rdata[k*IO_DW +: IO_DW];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            lat_cnt     <= '0;
            rd_op       <= 1'b0;
            b.cpu_rdata <= '0;
            b.err       <= 1'b0;
            b.mem_addr  <= '0;
            b.mem_wdata <= '0;
            b.mem_we    <= 1'b0;
            b.io_sel    <= '0;
            b.io_addr   <= '0;
            b.io_wdata  <= '0;
            b.io_rd     <= 1'b0;
            b.io_wr     <= 1'b0;
`ifdef MEMIO_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
        end else begin
            b.err <= 1'b0;
            case (state)
                IDLE: if (any) begin
                    rd_op <= is_read;
                    b.err <= multi | (!is_mem & bad_ch);
                    if (is_mem) begin
                        b.mem_addr  <= b.cpu_addr;
                        b.mem_wdata <= b.cpu_wdata;
                        b.mem_we    <= !is_read;
                        lat_cnt     <= '0;
                        state       <= MEM;
                    end else begin
                        b.io_addr  <= b.cpu_addr[IO_OFF_W-1:0];
                        b.io_wdata <= b.cpu_wdata[IO_DW-1:0];
                        // an empty select marks an out-of-range channel for the IO state
                        b.io_sel   <= bad_ch ? '0 : NUM_IO'(1) << b.cpu_addr[IO_OFF_W +: 4];
                        b.io_rd    <= !bad_ch & is_read;
                        b.io_wr    <= !bad_ch & !is_read;
`ifdef MEMIO_TIMEOUT_EN
                        tmo_cnt    <= '0;
`endif
                        state      <= IO;
                    end
                end
                MEM: if (b.mem_we) begin
                    b.mem_we <= 1'b0;
                    state    <= DONE;
                end else if (lat_cnt == 3'(MEM_LAT - 1)) begin
                    b.cpu_rdata <= b.mem_rdata;
                    state       <= DONE;
                end else begin
                    lat_cnt <= lat_cnt + 3'd1;
                end
                IO: if (b.io_sel == '0) begin
                    if (rd_op) b.cpu_rdata <= '0;
                    state <= DONE;
                end else if (|(b.io_ack & b.io_sel)) begin
                    if (rd_op) b.cpu_rdata <= DW'(sel_rdata);
                    b.io_sel <= '0;
                    b.io_rd  <= 1'b0;
                    b.io_wr  <= 1'b0;
                    state    <= DONE;
                end
`ifdef MEMIO_TIMEOUT_EN
                else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                    if (rd_op) b.cpu_rdata <= '0;
                    b.err    <= 1'b1;
                    b.io_sel <= '0;
                    b.io_rd  <= 1'b0;
                    b.io_wr  <= 1'b0;
                    state    <= DONE;
                end else begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_io_bridge.sv
// tb_mem_io_bridge: directed and randomized transactions against a transaction-level model of mem_io_bridge.
module tb_mem_io_bridge;
    localparam int DW = 32, AW = 32, IO_DW = 24, NUM_IO = 4, IO_OFF_W = 4, MEM_LAT = 1, TIMEOUT = 15;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    mem_io_bridge_if #(.DW(DW), .AW(AW), .IO_DW(IO_DW), .NUM_IO(NUM_IO), .IO_OFF_W(IO_OFF_W)) b ();

    mem_io_bridge #(.DW(DW), .AW(AW), .IO_DW(IO_DW), .NUM_IO(NUM_IO), .IO_OFF_W(IO_OFF_W),
                    .MEM_LAT(MEM_LAT), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .b(b.master)
    );

    logic [31:0] bmem    [0:255];
    logic [31:0] ref_mem [0:255];
    logic [31:0] exp_rd;
    int n_chk = 0;
    int n_fail = 0;

    assign b.mem_rdata = bmem[b.mem_addr[9:2]];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete CPU access: strobes for one cycle, then track the bridge until stall drops.
    task automatic txn(input logic mr, input logic mw, input logic ir, input logic iw,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int ack_dly, input bit no_ack, input logic [23:0] fd);
        logic        is_mem, is_rd, bad, multi;
        logic [3:0]  ch;
        logic [23:0] ch_data [NUM_IO];
        logic [31:0] next_rd;
        int          exp_lat, n, k, errs, wes;
        bit          done, exp_err;
        is_mem = mr | mw;
        is_rd  = mr ? 1'b1 : mw ? 1'b0 : ir;
        multi  = (int'(mr) + int'(mw) + int'(ir) + int'(iw)) > 1;
        ch     = addr[7:4];
        bad    = !is_mem && int'(ch) >= NUM_IO;
        for (int i = 0; i < NUM_IO; i++) ch_data[i] = 24'($urandom);
        if (!bad && !is_mem) ch_data[ch] = fd;
        next_rd = exp_rd;
        if (is_mem) begin
            exp_lat = is_rd ? 1 + MEM_LAT : 2;
            if (is_rd) next_rd = ref_mem[addr[9:2]];
            else ref_mem[addr[9:2]] = wdata;
        end else if (bad) begin
            exp_lat = 2;
            if (is_rd) next_rd = 32'h0;
        end else if (no_ack) begin
            exp_lat = 1 + TIMEOUT;
            if (is_rd) next_rd = 32'h0;
        end else begin
            exp_lat = 2 + ack_dly;
            if (is_rd) next_rd = {8'h00, fd};
        end
        exp_err = multi | bad | (!is_mem && no_ack);
        @(negedge clock);
        chk("idle_stall", b.cpu_stall, 0);
        chk("idle_err", b.err, 0);
        for (int i = 0; i < NUM_IO; i++) b.io_rdata[i*IO_DW +: IO_DW] = ch_data[i];
        {b.cpu_mread, b.cpu_mwrite, b.cpu_ioread, b.cpu_iowrite} = {mr, mw, ir, iw};
        b.cpu_addr  = addr;
        b.cpu_wdata = wdata;
        b.io_ack    = '0;
        #1 chk("stall_on_strobe", b.cpu_stall, 1);
        n = 1; k = 0; errs = 0; wes = 0; done = 0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clock);
            {b.cpu_mread, b.cpu_mwrite, b.cpu_ioread, b.cpu_iowrite} = 4'b0;
            b.io_ack = '0;
            if (b.err) errs++;
            if (b.mem_we) begin
                wes++;
                chk("mem_addr", b.mem_addr, addr);
                chk("mem_wdata", b.mem_wdata, wdata);
                bmem[b.mem_addr[9:2]] = b.mem_wdata;
            end
            if (!b.cpu_stall) begin
                done = 1;
                chk("done_rdata", b.cpu_rdata, next_rd);
                chk("done_bus_idle", {b.mem_we, b.io_rd, b.io_wr, b.io_sel}, 0);
            end else begin
                n++;
                if (!is_mem) begin
                    chk("io_sel", b.io_sel, bad ? 0 : 64'(1) << ch);
                    chk("io_rd", b.io_rd, !bad && is_rd);
                    chk("io_wr", b.io_wr, !bad && !is_rd);
                    if (!bad) chk("io_addr", b.io_addr, addr[3:0]);
                    if (!bad && !is_rd) chk("io_wdata", b.io_wdata, wdata[23:0]);
                    if (!bad && !no_ack) begin
                        if (k == ack_dly) b.io_ack[ch] = 1'b1;
                        else b.io_ack[(int'(ch) + 1 + int'($urandom_range(0, NUM_IO - 2))) % NUM_IO] = 1'b1;
                    end
                    k++;
                end
            end
        end
        chk("txn_finished", done, 1);
        chk("latency", n, exp_lat);
        chk("err_pulses", errs, exp_err);
        chk("mem_we_cycles", wes, is_mem && !is_rd);
        exp_rd = next_rd;
    endtask

    initial begin
        logic [31:0] v, a;
        logic [3:0]  s;
        {b.cpu_mread, b.cpu_mwrite, b.cpu_ioread, b.cpu_iowrite} = 4'b0;
        b.cpu_addr = '0;
        b.cpu_wdata = '0;
        b.io_rdata = '0;
        b.io_ack = '0;
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            bmem[i] = v;
            ref_mem[i] = v;
        end
        exp_rd = 32'h0;
        repeat (3) @(negedge clock);
        chk("rst_rdata", b.cpu_rdata, 0);
        chk("rst_err", b.err, 0);
        chk("rst_stall", b.cpu_stall, 0);
        chk("rst_mem", {b.mem_we, b.mem_addr, b.mem_wdata}, 0);
        chk("rst_io", {b.io_sel, b.io_rd, b.io_wr, b.io_addr, b.io_wdata}, 0);
        reset_n = 1'b1;
        bmem[8'h40] = 32'hDEADBEEF;
        ref_mem[8'h40] = 32'hDEADBEEF;
        txn(1, 0, 0, 0, 32'h100, 32'h0, 0, 0, 24'h0);
        txn(0, 1, 0, 0, 32'h40, 32'h12345678, 0, 0, 24'h0);
        txn(0, 0, 1, 0, 32'h23, 32'h0, 4, 0, 24'hABCDEF);
        txn(0, 0, 0, 1, 32'h7C, 32'h00FFFFFF, 0, 0, 24'h0);
        txn(0, 0, 1, 0, 32'h51, 32'h0, 0, 0, 24'h0);
        txn(0, 0, 0, 1, 32'h3A, 32'hCAFE1234, 0, 0, 24'h0);
        txn(1, 0, 1, 0, 32'h100, 32'h0, 0, 0, 24'h0);
        txn(0, 1, 1, 1, 32'h2C4, 32'h0BADF00D, 0, 0, 24'h0);
`ifdef MEMIO_TIMEOUT_EN
        txn(0, 0, 1, 0, 32'h11, 32'h0, 0, 1, 24'h0);
`endif
        for (int t = 0; t < 40; t++) begin
            s = 4'($urandom);
            if ($urandom_range(0, 3) != 0 || s == 4'b0) s = 4'b1 << $urandom_range(0, 3);
            a = $urandom;
            a[7:4] = 4'($urandom_range(0, 5));
            txn(s[3], s[2], s[1], s[0], a, $urandom, $urandom_range(0, 6), 0, 24'($urandom));
        end
        @(negedge clock);
        b.cpu_ioread = 1'b1;
        b.cpu_addr = 32'h15;
        @(negedge clock);
        b.cpu_ioread = 1'b0;
        repeat (2) @(negedge clock);
        chk("mid_io_rd_before_reset", b.io_rd, 1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_io_rd", b.io_rd, 0);
        chk("rst_mid_stall", b.cpu_stall, 0);
        chk("rst_mid_sel", b.io_sel, 0);
        chk("rst_mid_rdata", b.cpu_rdata, 0);
        exp_rd = 32'h0;
        @(negedge clock);
        reset_n = 1'b1;
        txn(1, 0, 0, 0, 32'h100, 32'h0, 0, 0, 24'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
